// File: rtl/digit_pair_unpacker.sv
// -----------------------------------------------------------------------------
// digit_pair_unpacker
//
// Receiving end of the packed BCD digit-pair bus.  Each accepted byte carries
// two BCD digits: the high nibble is the earlier digit and the low nibble the
// later one.  Pairs with a non-decimal nibble are dropped and counted.  Good
// digits go into a small circular FIFO.  They are then replayed one per beat on
// a valid/ready stream, both as BCD and as ASCII.  An optional '.' beat follows
// the very first digit, so the stream reads like "2.718...".
//
// Ports:
//   i_clk           clock, everything on the rising edge
//   i_reset         synchronous active-high reset
//   i_clear         synchronous flush of FIFO, state, counters and error flag
//   i_in_valid      i_in_pair holds a pair
//   o_in_ready      room for a whole pair (two free slots)
//   i_in_pair       {earlier digit, later digit} in BCD
//   o_out_valid     o_out_digit / o_out_ascii hold a beat
//   i_out_ready     sink takes the current beat
//   o_out_digit     BCD digit, 0 on the dot beat
//   o_out_ascii     0x30 + digit, or 0x2E on the dot beat
//   o_out_is_dot    current beat is the inserted '.'
//   o_level         digits held in the FIFO
//   o_digit_count   digits popped, wraps; dot beats excluded
//   o_err_count     rejected pairs, saturating
//   o_err_bcd       sticky rejected-pair flag
// -----------------------------------------------------------------------------
module digit_pair_unpacker #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int DOT_EN = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [7:0]               i_in_pair,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [3:0]               o_out_digit,
  output logic [7:0]               o_out_ascii,
  output logic                     o_out_is_dot,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNT_W-1:0]         o_digit_count,
  output logic [CNT_W-1:0]         o_err_count,
  output logic                     o_err_bcd
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_FIRST,
    S_DOT,
    S_STREAM
  } state_t;

  logic [3:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  state_t           r_state;
  logic [CNT_W-1:0] r_digitCount;
  logic [CNT_W-1:0] r_errCount;
  logic             r_errBcd;

  logic [3:0]       w_hi;
  logic [3:0]       w_lo;
  logic             w_pairOk;
  logic             w_inReady;
  logic             w_accept;
  logic             w_push;
  logic             w_reject;
  logic             w_notEmpty;
  logic [3:0]       w_head;
  logic             w_flush;
  state_t           w_nextState;
  logic             w_outValid;
  logic             w_isDot;
  logic             w_pop;

  // Input-side decode.  A pair is only taken when two slots are free, judged
  // from the registered level alone so a pop in the same cycle gives no
  // extra credit.  A pair with either nibble above 9 is accepted off the bus
  // but never written.
  always_comb begin
    w_hi       = i_in_pair[7:4];
    w_lo       = i_in_pair[3:0];
    w_pairOk   = (w_hi <= 4'd9) && (w_lo <= 4'd9);
    w_inReady  = (r_level <= LW'(DEPTH - 2));
    w_accept   = i_in_valid && w_inReady;
    w_push     = w_accept && w_pairOk;
    w_reject   = w_accept && !w_pairOk;
    w_notEmpty = (r_level != '0);
    w_head     = r_mem[r_rdPtr];
    w_flush    = i_reset || i_clear;
  end

  // Output sequencer.  The first digit goes out, then (optionally) a single
  // dot beat that does not touch the FIFO, then plain streaming forever until
  // reset or clear brings us back to the first digit.
  always_comb begin
    w_nextState = r_state;
    w_outValid  = 1'b0;
    w_isDot     = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_FIRST: begin
        w_outValid = w_notEmpty;
        w_pop      = w_notEmpty && i_out_ready;
        if (w_pop) begin
          w_nextState = (DOT_EN != 0) ? S_DOT : S_STREAM;
        end
      end
      S_DOT: begin
        w_outValid = 1'b1;
        w_isDot    = 1'b1;
        if (i_out_ready) begin
          w_nextState = S_STREAM;
        end
      end
      S_STREAM: begin
        w_outValid = w_notEmpty;
        w_pop      = w_notEmpty && i_out_ready;
      end
      default: begin
        w_nextState = S_FIRST;
      end
    endcase
  end

  // Digit storage.  Both digits of a good pair land in consecutive slots.
  // The head slot is never overwritten while it is occupied because a push
  // only happens with at least two free slots.
  always_ff @(posedge i_clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wrPtr]          <= w_hi;
      r_mem[r_wrPtr + AW'(1)] <= w_lo;
    end
  end

  // Pointers, occupancy, sequencer state and counters.  Clear behaves exactly
  // like reset and wins over any handshake in the same cycle, so neither the
  // push nor the pop of that cycle leaves a trace.
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_level      <= '0;
      r_state      <= S_FIRST;
      r_digitCount <= '0;
      r_errCount   <= '0;
      r_errBcd     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(2);
      end
      if (w_pop) begin
        r_rdPtr      <= r_rdPtr + AW'(1);
        r_digitCount <= r_digitCount + CNT_W'(1);
      end
      r_level <= r_level + (w_push ? LW'(2) : LW'(0)) - (w_pop ? LW'(1) : LW'(0));
      if (w_reject) begin
        r_errBcd <= 1'b1;
        if (r_errCount != '1) begin
          r_errCount <= r_errCount + CNT_W'(1);
        end
      end
    end
  end

  // Output formatting.  ASCII is just '0' plus the digit, except on the dot
  // beat where the digit reads as zero and the character is '.'.
  always_comb begin
    o_in_ready    = w_inReady;
    o_out_valid   = w_outValid;
    o_out_is_dot  = w_isDot;
    o_out_digit   = w_isDot ? 4'd0 : w_head;
    o_out_ascii   = w_isDot ? 8'h2E : (8'h30 + {4'h0, w_head});
    o_level       = r_level;
    o_digit_count = r_digitCount;
    o_err_count   = r_errCount;
    o_err_bcd     = r_errBcd;
  end

endmodule

// File: tb/tb_digit_pair_unpacker.sv
// -----------------------------------------------------------------------------
// tb_digit_pair_unpacker
//
// Self-checking bench for digit_pair_unpacker.  A behavioural model keeps
// the buffered digits in a queue, plus how many digits have left since the
// last flush and whether the dot has been sent.  Every cycle all observable
// outputs are compared against that model, followed by directed scenarios and
// a long randomized run.
// -----------------------------------------------------------------------------
module tb_digit_pair_unpacker;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int DOT_EN = 1;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             inValid;
  logic             inReady;
  logic [7:0]       inPair;
  logic             outValid;
  logic             outReady;
  logic [3:0]       outDigit;
  logic [7:0]       outAscii;
  logic             outIsDot;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] digitCount;
  logic [CNT_W-1:0] errCount;
  logic             errBcd;

  int vecCount  = 0;
  int missCount = 0;

  int  mQ[$];
  int  mDigitsOut;
  bit  mDotDone;
  int  mDigCnt;
  int  mErrCnt;
  bit  mErrFlag;
  bit  lastAccept;
  int  seenAscii[$];

  digit_pair_unpacker #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .DOT_EN(DOT_EN)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_clear      (clear),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_in_pair    (inPair),
    .o_out_valid  (outValid),
    .i_out_ready  (outReady),
    .o_out_digit  (outDigit),
    .o_out_ascii  (outAscii),
    .o_out_is_dot (outIsDot),
    .o_level      (level),
    .o_digit_count(digitCount),
    .o_err_count  (errCount),
    .o_err_bcd    (errBcd)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The one place comparisons are made and counted.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Model helpers: a flush empties everything; the dot is owed exactly once,
  // right after the first digit has gone out.
  function automatic void modelFlush();
    mQ.delete();
    mDigitsOut = 0;
    mDotDone   = 1'b0;
    mDigCnt    = 0;
    mErrCnt    = 0;
    mErrFlag   = 1'b0;
  endfunction

  function automatic bit dotPending();
    return (DOT_EN != 0) && (mDigitsOut == 1) && !mDotDone;
  endfunction

  // Compare every observable output with what the model says right now.
  task automatic checkAll();
    bit expValid;
    bit expDot;
    int expDigit;
    expDot   = dotPending();
    expValid = expDot || (mQ.size() > 0);
    expDigit = expDot ? 0 : ((mQ.size() > 0) ? mQ[0] : 0);
    checkOutput("inReady", 32'(inReady), 32'((DEPTH - mQ.size()) >= 2));
    checkOutput("outValid", 32'(outValid), 32'(expValid));
    checkOutput("outIsDot", 32'(outIsDot), 32'(expDot));
    checkOutput("level", 32'(level), 32'(mQ.size()));
    checkOutput("digitCount", 32'(digitCount), 32'(mDigCnt));
    checkOutput("errCount", 32'(errCount), 32'(mErrCnt));
    checkOutput("errBcd", 32'(errBcd), 32'(mErrFlag));
    if (expValid) begin
      checkOutput("outDigit", 32'(outDigit), 32'(expDigit));
      checkOutput("outAscii", 32'(outAscii), expDot ? 32'h2E : 32'(8'h30 + expDigit));
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, advance the
  // model for whatever handshakes the rules say happen at the next rising edge.
  task automatic applyStimulus(input bit v, input logic [7:0] pair, input bit rdy, input bit clr);
    bit expReady;
    bit expValid;
    bit expDot;
    inValid  = v;
    inPair   = pair;
    outReady = rdy;
    clear    = clr;
    #1;
    checkAll();
    if (outValid && outReady) begin
      seenAscii.push_back(int'(outAscii));
    end
    expReady   = (DEPTH - mQ.size()) >= 2;
    expDot     = dotPending();
    expValid   = expDot || (mQ.size() > 0);
    lastAccept = v && expReady && !clr;
    if (clr) begin
      modelFlush();
    end else begin
      if (expValid && rdy) begin
        if (expDot) begin
          mDotDone = 1'b1;
        end else begin
          void'(mQ.pop_front());
          mDigitsOut++;
          mDigCnt = (mDigCnt + 1) % (1 << CNT_W);
        end
      end
      if (v && expReady) begin
        if (pair[7:4] <= 4'd9 && pair[3:0] <= 4'd9) begin
          mQ.push_back(int'(pair[7:4]));
          mQ.push_back(int'(pair[3:0]));
        end else begin
          mErrFlag = 1'b1;
          if (mErrCnt != (1 << CNT_W) - 1) mErrCnt++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a pair until it is taken, giving up after a fixed number of cycles.
  task automatic sendPair(input logic [7:0] pair, input bit rdy);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      applyStimulus(1'b1, pair, rdy, 1'b0);
      done = lastAccept;
    end
    if (!done) checkOutput("sendTimeout", 32'(inReady), 32'd1);
    inValid = 1'b0;
  endtask

  // Let the sink take everything that is buffered.
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (mQ.size() == 0 && !dotPending()) break;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drainLevel", 32'(level), 32'd0);
  endtask

  task automatic checkSeen(input string tag, input int want[$]);
    checkOutput({tag, "Len"}, 32'(seenAscii.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < seenAscii.size(); i++) begin
      checkOutput(tag, 32'(seenAscii[i]), 32'(want[i]));
    end
  endtask

  // Main sequence: reset, directed scenarios, then randomized traffic.
  initial begin
    int  wantSeq[$];
    bit  v;
    bit  rdy;
    bit  clr;
    logic [7:0] pair;
    logic [3:0] hi;
    logic [3:0] lo;

    reset    = 1'b1;
    clear    = 1'b0;
    inValid  = 1'b0;
    inPair   = 8'h00;
    outReady = 1'b0;
    modelFlush();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rstLevel", 32'(level), 32'd0);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstErrBcd", 32'(errBcd), 32'd0);
    checkOutput("rstInReady", 32'(inReady), 32'd1);
    checkOutput("rstDigitCount", 32'(digitCount), 32'd0);

    $display("[TB] normal stream with dot");
    seenAscii.delete();
    sendPair(8'h27, 1'b1);
    sendPair(8'h18, 1'b1);
    sendPair(8'h28, 1'b1);
    drain();
    wantSeq = '{32'h32, 32'h2E, 32'h37, 32'h31, 32'h38, 32'h32, 32'h38};
    checkSeen("dotSeq", wantSeq);
    checkOutput("dotDigitCount", 32'(digitCount), 32'd6);

    $display("[TB] bad BCD pair");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    seenAscii.delete();
    sendPair(8'h2A, 1'b1);
    sendPair(8'h71, 1'b1);
    drain();
    checkOutput("badErrBcd", 32'(errBcd), 32'd1);
    checkOutput("badErrCount", 32'(errCount), 32'd1);
    wantSeq = '{32'h37, 32'h2E, 32'h31};
    checkSeen("badSeq", wantSeq);

    $display("[TB] back-pressure and full");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    seenAscii.delete();
    sendPair(8'h12, 1'b0);
    sendPair(8'h34, 1'b0);
    sendPair(8'h56, 1'b0);
    sendPair(8'h78, 1'b0);
    checkOutput("fullLevel", 32'(level), 32'd8);
    checkOutput("fullInReady", 32'(inReady), 32'd0);
    repeat (3) applyStimulus(1'b1, 8'h90, 1'b0, 1'b0);
    checkOutput("fullLevelHeld", 32'(level), 32'd8);
    sendPair(8'h90, 1'b1);
    drain();
    wantSeq = '{32'h31, 32'h2E, 32'h32, 32'h33, 32'h34, 32'h35,
                32'h36, 32'h37, 32'h38, 32'h39, 32'h30};
    checkSeen("fullSeq", wantSeq);

    $display("[TB] mid-stream clear");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendPair(8'h27, 1'b0);
    sendPair(8'hB1, 1'b0);
    sendPair(8'h18, 1'b0);
    sendPair(8'h3C, 1'b0);
    sendPair(8'h33, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("preClrLevel", 32'(level), 32'd4);
    applyStimulus(1'b1, 8'h45, 1'b1, 1'b1);
    checkOutput("clrLevel", 32'(level), 32'd0);
    checkOutput("clrErrCount", 32'(errCount), 32'd0);
    checkOutput("clrErrBcd", 32'(errBcd), 32'd0);
    seenAscii.delete();
    sendPair(8'h27, 1'b1);
    drain();
    wantSeq = '{32'h32, 32'h2E, 32'h37};
    checkSeen("clrSeq", wantSeq);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 1500; n++) begin
      hi = 4'($urandom_range(0, 9));
      lo = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) hi = 4'($urandom_range(10, 15));
        else                           lo = 4'($urandom_range(10, 15));
      end
      pair = {hi, lo};
      v    = ($urandom_range(0, 2) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      applyStimulus(v, pair, rdy, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
